// File: rtl/fmap_pkg.sv
// Shared definitions for the feature-map buffer controller: FSM state encoding
// and small state-decode helpers.
package fmap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fmap_state_e;

    localparam int NUM_READERS = 3;

    // Readers may be served, and may report completion, only while a frame is in flight.
    function automatic logic is_active(input fmap_state_e s);
        return (s == ST_FILL) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/fmap_rd_gate.sv
// Per-reader gate: grants reads only below the committed fill level, tracks the
// buffer's 1-cycle read latency and holds the reader's sticky done flag.
module fmap_rd_gate #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_active,
    input  logic                  i_clear,
    input  logic [ADDR_WIDTH:0]   i_fill_count,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_done,
    output logic                  o_grant,
    output logic                  o_en,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_valid,
    output logic                  o_done_seen
);

    logic grant;
    logic valid_d;
    logic valid_q;
    logic done_d;
    logic done_q;

    // Strictly-below compare excludes the word being written this very cycle.
    always_comb begin
        grant   = i_req & i_active & ({1'b0, i_addr} < i_fill_count);
        valid_d = grant;
        done_d  = i_clear ? 1'b0 : (done_q | (i_done & i_active));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign o_grant     = grant;
    assign o_en        = grant;
    assign o_addr      = i_active ? i_addr : '0;
    assign o_valid     = valid_q;
    assign o_done_seen = done_q | (i_done & i_active);

endmodule

// File: rtl/fmap_buffer_ctrl.sv
// Feature-map buffer controller: C1 fills one frame sequentially while three
// independent readers consume already-written words; frame ends when all report done.
module fmap_buffer_ctrl
    import fmap_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int FRAME_LEN  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_c1_valid,
    output logic                  o_c1_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,

    input  logic                  i_rd_req_a,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr_a,
    output logic                  o_rd_grant_a,
    output logic                  o_rd_en_a,
    output logic [ADDR_WIDTH-1:0] o_rd_addr_a,
    output logic                  o_rd_valid_a,
    input  logic                  i_done_a,

    input  logic                  i_rd_req_b,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr_b,
    output logic                  o_rd_grant_b,
    output logic                  o_rd_en_b,
    output logic [ADDR_WIDTH-1:0] o_rd_addr_b,
    output logic                  o_rd_valid_b,
    input  logic                  i_done_b,

    input  logic                  i_rd_req_c,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr_c,
    output logic                  o_rd_grant_c,
    output logic                  o_rd_en_c,
    output logic [ADDR_WIDTH-1:0] o_rd_addr_c,
    output logic                  o_rd_valid_c,
    input  logic                  i_done_c,

    output logic [ADDR_WIDTH:0]   o_fill_count,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam logic [ADDR_WIDTH:0] FRAME_LEN_W = (ADDR_WIDTH + 1)'(FRAME_LEN);

    fmap_state_e             state_q;
    fmap_state_e             state_d;
    logic [ADDR_WIDTH:0]     fill_q;
    logic [ADDR_WIDTH:0]     fill_d;
    logic [ADDR_WIDTH:0]     fill_inc;
    logic                    busy_q;
    logic                    busy_d;
    logic                    frame_done_q;
    logic                    frame_done_d;
    logic                    active;
    logic                    start_clr;
    logic                    c1_ready;
    logic                    wr_en;
    logic [NUM_READERS-1:0]  done_seen;

    assign active    = is_active(state_q);
    assign start_clr = (state_q == ST_IDLE) & i_start;
    assign c1_ready  = (state_q == ST_FILL) & (fill_q < FRAME_LEN_W);
    assign wr_en     = i_c1_valid & c1_ready;
    assign fill_inc  = fill_q + 1'b1;

    // done_seen already folds in a same-cycle i_done so DRAIN can exit without an extra cycle.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    fill_d  = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (wr_en) begin
                    fill_d = fill_inc;
                    if (fill_inc == FRAME_LEN_W) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (&done_seen) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fill_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_c1_ready   = c1_ready;
    assign o_wr_en      = wr_en;
    assign o_wr_addr    = fill_q[ADDR_WIDTH-1:0];
    assign o_fill_count = fill_q;
    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;

    fmap_rd_gate #(.ADDR_WIDTH(ADDR_WIDTH)) u_gate_a (
        .clk(clk), .rst(rst), .i_active(active), .i_clear(start_clr),
        .i_fill_count(fill_q), .i_req(i_rd_req_a), .i_addr(i_rd_addr_a), .i_done(i_done_a),
        .o_grant(o_rd_grant_a), .o_en(o_rd_en_a), .o_addr(o_rd_addr_a),
        .o_valid(o_rd_valid_a), .o_done_seen(done_seen[0])
    );

    fmap_rd_gate #(.ADDR_WIDTH(ADDR_WIDTH)) u_gate_b (
        .clk(clk), .rst(rst), .i_active(active), .i_clear(start_clr),
        .i_fill_count(fill_q), .i_req(i_rd_req_b), .i_addr(i_rd_addr_b), .i_done(i_done_b),
        .o_grant(o_rd_grant_b), .o_en(o_rd_en_b), .o_addr(o_rd_addr_b),
        .o_valid(o_rd_valid_b), .o_done_seen(done_seen[1])
    );

    fmap_rd_gate #(.ADDR_WIDTH(ADDR_WIDTH)) u_gate_c (
        .clk(clk), .rst(rst), .i_active(active), .i_clear(start_clr),
        .i_fill_count(fill_q), .i_req(i_rd_req_c), .i_addr(i_rd_addr_c), .i_done(i_done_c),
        .o_grant(o_rd_grant_c), .o_en(o_rd_en_c), .o_addr(o_rd_addr_c),
        .o_valid(o_rd_valid_c), .o_done_seen(done_seen[2])
    );

endmodule

// File: tb/tb_fmap_buffer_ctrl.sv
// Bench for fmap_buffer_ctrl (ADDR_WIDTH=4, FRAME_LEN=16): directed vector table,
// hand-written frame sequences and random traffic against a frame-level reference model.
module tb_fmap_buffer_ctrl;

    localparam int AW = 4;
    localparam int FL = 16;

    logic          clk;
    logic          rst;
    logic          st;
    logic          c1v;
    logic [2:0]    req;
    logic [AW-1:0] aa, ab, ac;
    logic [2:0]    dn;

    logic          c1_ready, wr_en;
    logic [AW-1:0] wr_addr;
    logic          g_a, g_b, g_c, en_a, en_b, en_c, v_a, v_b, v_c;
    logic [AW-1:0] ra_a, ra_b, ra_c;
    logic [AW:0]   fill;
    logic          busy, fdone;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: frame phase 0=idle 1=fill 2=drain 3=done.
    int       m_phase;
    int       m_fill;
    bit [2:0] m_done;
    bit [2:0] m_valid;
    bit [2:0] m_grant;

    fmap_buffer_ctrl #(.ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .i_start(st), .i_c1_valid(c1v), .o_c1_ready(c1_ready),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr),
        .i_rd_req_a(req[0]), .i_rd_addr_a(aa), .o_rd_grant_a(g_a), .o_rd_en_a(en_a),
        .o_rd_addr_a(ra_a), .o_rd_valid_a(v_a), .i_done_a(dn[0]),
        .i_rd_req_b(req[1]), .i_rd_addr_b(ab), .o_rd_grant_b(g_b), .o_rd_en_b(en_b),
        .o_rd_addr_b(ra_b), .o_rd_valid_b(v_b), .i_done_b(dn[1]),
        .i_rd_req_c(req[2]), .i_rd_addr_c(ac), .o_rd_grant_c(g_c), .o_rd_en_c(en_c),
        .o_rd_addr_c(ra_c), .o_rd_valid_c(v_c), .i_done_c(dn[2]),
        .o_fill_count(fill), .o_busy(busy), .o_frame_done(fdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          st;
        logic          c1v;
        logic [2:0]    req;
        logic [AW-1:0] addr;
        logic [2:0]    dn;
        logic          e_ready;
        logic          e_wren;
        logic [AW-1:0] e_wraddr;
        logic [2:0]    e_grant;
        logic [2:0]    e_valid;
        logic [AW:0]   e_fill;
        logic          e_busy;
        logic          e_fdone;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit          act;
        bit          e_ready;
        bit          e_wren;
        logic [AW-1:0] e_ra [3];
        logic [AW-1:0] addr_k [3];
        addr_k[0] = aa; addr_k[1] = ab; addr_k[2] = ac;
        act     = (m_phase == 1) || (m_phase == 2);
        e_ready = (m_phase == 1) && (m_fill < FL);
        e_wren  = c1v && e_ready;
        for (int k = 0; k < 3; k++) begin
            m_grant[k] = req[k] && act && (int'(addr_k[k]) < m_fill);
            e_ra[k]    = act ? addr_k[k] : '0;
        end
        chk("m_ctl", {28'd0, c1_ready, wr_en, busy, fdone},
            {28'd0, e_ready, e_wren, m_phase != 0, m_phase == 3});
        chk("m_wr_addr", 32'(wr_addr), 32'(m_fill % FL));
        chk("m_fill", 32'(fill), 32'(m_fill));
        chk("m_grant", {29'd0, g_c, g_b, g_a}, {29'd0, m_grant});
        chk("m_rd_en", {29'd0, en_c, en_b, en_a}, {29'd0, m_grant});
        chk("m_valid", {29'd0, v_c, v_b, v_a}, {29'd0, m_valid});
        chk("m_rd_addr", {20'd0, ra_c, ra_b, ra_a}, {20'd0, e_ra[2], e_ra[1], e_ra[0]});
    endtask

    task automatic model_update();
        if (rst) begin
            m_phase = 0; m_fill = 0; m_done = '0; m_valid = '0;
        end else begin
            m_valid = m_grant;
            case (m_phase)
                0: if (st) begin m_fill = 0; m_done = '0; m_phase = 1; end
                1: begin
                    if (c1v && m_fill < FL) m_fill++;
                    m_done |= dn;
                    if (m_fill == FL) m_phase = 2;
                end
                2: begin
                    m_done |= dn;
                    if (m_done == 3'b111) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic apply(input logic i_st, input logic i_c1v, input logic [2:0] i_req,
                         input logic [AW-1:0] i_aa, input logic [AW-1:0] i_ab,
                         input logic [AW-1:0] i_ac, input logic [2:0] i_dn, input logic i_rst);
        st = i_st; c1v = i_c1v; req = i_req; aa = i_aa; ab = i_ab; ac = i_ac;
        dn = i_dn; rst = i_rst;
        #2;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b1, 3'b000, '0, '0, '0, 3'b000, 1'b0);
            tick();
        end
    endtask

    initial begin
        st = 0; c1v = 0; req = '0; aa = '0; ab = '0; ac = '0; dn = '0; rst = 1'b1;
        m_phase = 0; m_fill = 0; m_done = '0; m_valid = '0; m_grant = '0;
        repeat (2) @(posedge clk);
        #1;

        //                st c1v req     addr dn      rdy wen wa  grant   valid   fill busy fd
        tbl[0] = '{1'b0, 1'b0, 3'b000, 4'd0, 3'b000, 1'b0, 1'b0, 4'd0, 3'b000, 3'b000, 5'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 3'b000, 4'd0, 3'b000, 1'b0, 1'b0, 4'd0, 3'b000, 3'b000, 5'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 3'b001, 4'd0, 3'b000, 1'b1, 1'b1, 4'd0, 3'b000, 3'b000, 5'd0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 3'b111, 4'd0, 3'b000, 1'b1, 1'b1, 4'd1, 3'b111, 3'b000, 5'd1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 3'b001, 4'd1, 3'b000, 1'b1, 1'b0, 4'd2, 3'b001, 3'b111, 5'd2, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 3'b010, 4'd2, 3'b000, 1'b1, 1'b0, 4'd2, 3'b000, 3'b001, 5'd2, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 3'b100, 4'd1, 3'b001, 1'b1, 1'b0, 4'd2, 3'b100, 3'b000, 5'd2, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 3'b000, 4'd0, 3'b000, 1'b1, 1'b1, 4'd2, 3'b000, 3'b100, 5'd2, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 3'b000, 4'd0, 3'b000, 1'b1, 1'b0, 4'd3, 3'b000, 3'b000, 5'd3, 1'b1, 1'b0};

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].st, tbl[i].c1v, tbl[i].req, tbl[i].addr, tbl[i].addr, tbl[i].addr,
                  tbl[i].dn, 1'b0);
            chk($sformatf("vec%0d_ctl", i), {30'd0, c1_ready, wr_en}, {30'd0, tbl[i].e_ready, tbl[i].e_wren});
            chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].e_wraddr));
            chk($sformatf("vec%0d_grant", i), {29'd0, g_c, g_b, g_a}, {29'd0, tbl[i].e_grant});
            chk($sformatf("vec%0d_valid", i), {29'd0, v_c, v_b, v_a}, {29'd0, tbl[i].e_valid});
            chk($sformatf("vec%0d_fill", i), 32'(fill), 32'(tbl[i].e_fill));
            chk($sformatf("vec%0d_stat", i), {30'd0, busy, fdone}, {30'd0, tbl[i].e_busy, tbl[i].e_fdone});
            tick();
        end

        // Full frame: write-address sweep, read-after-write hazard, shared-address reads, done ordering.
        apply(1'b0, 1'b0, 3'b000, '0, '0, '0, 3'b000, 1'b1);
        tick();
        apply(1'b1, 1'b0, 3'b000, '0, '0, '0, 3'b000, 1'b0);
        tick();
        for (int i = 0; i < FL; i++) begin
            logic [2:0] r;
            logic [AW-1:0] a;
            r = (i == 5 || i == 6) ? 3'b001 : (i == 10) ? 3'b111 : 3'b000;
            a = (i == 5 || i == 6) ? AW'(5) : AW'(3);
            apply(1'b0, 1'b1, r, a, AW'(3), AW'(3), (i == 12) ? 3'b011 : 3'b000, 1'b0);
            chk("seq_wr_addr", 32'(wr_addr), 32'(i));
            if (i == 5)  chk("raw_same_addr_grant", 32'(g_a), 32'd0);
            if (i == 6)  chk("raw_after_write_grant", 32'(g_a), 32'd1);
            if (i == 7)  chk("raw_valid_a", 32'(v_a), 32'd1);
            if (i == 10) chk("shared_addr_grant", {29'd0, g_c, g_b, g_a}, 32'h7);
            if (i == 11) chk("shared_addr_valid", {29'd0, v_c, v_b, v_a}, 32'h7);
            tick();
        end
        apply(1'b0, 1'b1, 3'b000, '0, '0, '0, 3'b100, 1'b0);
        chk("drain_fill", 32'(fill), 32'd16);
        chk("drain_ready", {30'd0, c1_ready, wr_en}, 32'd0);
        chk("drain_busy", {30'd0, busy, fdone}, 32'h2);
        tick();
        apply(1'b0, 1'b0, 3'b000, '0, '0, '0, 3'b000, 1'b0);
        chk("done_pulse", {30'd0, busy, fdone}, 32'h3);
        tick();
        apply(1'b0, 1'b0, 3'b000, '0, '0, '0, 3'b000, 1'b0);
        chk("back_to_idle", {30'd0, busy, fdone}, 32'h0);
        tick();

        // Start pulses during DRAIN must not restart the frame.
        apply(1'b1, 1'b0, 3'b000, '0, '0, '0, 3'b000, 1'b0);
        tick();
        write_n(FL);
        for (int j = 0; j < 2; j++) begin
            apply(1'b1, 1'b1, 3'b000, '0, '0, '0, 3'b000, 1'b0);
            chk("drain_start_fill", 32'(fill), 32'd16);
            chk("drain_start_wr", {30'd0, c1_ready, wr_en}, 32'd0);
            tick();
        end
        apply(1'b0, 1'b0, 3'b000, '0, '0, '0, 3'b111, 1'b0);
        chk("drain_start_busy", 32'(busy), 32'd1);
        tick();
        apply(1'b0, 1'b0, 3'b000, '0, '0, '0, 3'b000, 1'b0);
        tick();

        // Mid-frame reset, then a clean restart from address 0.
        apply(1'b1, 1'b0, 3'b000, '0, '0, '0, 3'b000, 1'b0);
        tick();
        write_n(7);
        apply(1'b0, 1'b1, 3'b111, '0, '0, '0, 3'b000, 1'b1);
        chk("pre_rst_fill", 32'(fill), 32'd7);
        tick();
        apply(1'b0, 1'b1, 3'b111, AW'(2), AW'(2), AW'(2), 3'b000, 1'b0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_ctl", {28'd0, c1_ready, wr_en, busy, fdone}, 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_grant_en", {26'd0, en_c, en_b, en_a, g_c, g_b, g_a}, 32'd0);
        chk("rst_valid", {29'd0, v_c, v_b, v_a}, 32'd0);
        chk("rst_rd_addr", {20'd0, ra_c, ra_b, ra_a}, 32'd0);
        tick();
        apply(1'b1, 1'b0, 3'b000, '0, '0, '0, 3'b000, 1'b0);
        tick();
        apply(1'b0, 1'b1, 3'b000, '0, '0, '0, 3'b000, 1'b0);
        chk("restart_wr", {27'd0, wr_en, wr_addr}, 32'h10);
        tick();

        // Random traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            apply(($urandom % 8) == 0, ($urandom % 4) != 0, 3'($urandom),
                  AW'($urandom), AW'($urandom), AW'($urandom),
                  {($urandom % 12) == 0, ($urandom % 12) == 0, ($urandom % 12) == 0},
                  ($urandom % 200) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
